// File: rtl/vga_pkg.sv
// Shared VGA constants: 640x480 display timing and the half-resolution framebuffer geometry.
package vga_pkg;

    localparam int H_DISP  = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;

    localparam int V_DISP  = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam int FB_HRES   = 320;
    localparam int FB_VRES   = 240;
    localparam int FB_PIX_W  = 4;
    localparam int FB_ADDR_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DISP_RD = 2'd1,
        ST_WR      = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the requester not granted last wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic prio_r;

    // One-hot grant selection from the current tie-break pointer
    always_comb begin
        gnt = 2'b00;
        if (!enable) begin
            gnt = 2'b00;
        end else if (req == 2'b11) begin
            gnt = prio_r ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    // Pointer moves to the other requester after each grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_r <= 1'b0;
        end else if (gnt[0]) begin
            prio_r <= 1'b1;
        end else if (gnt[1]) begin
            prio_r <= 1'b0;
        end else begin
            prio_r <= prio_r;
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Double-buffered framebuffer port arbiter: display fetch has priority, two writers share
// the remaining cycles round-robin, and bank swaps happen at vertical-blank start.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int HRES   = FB_HRES,
    parameter int VRES   = FB_VRES,
    parameter int PIX_W  = FB_PIX_W,
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        row,
    input  logic [9:0]        col,
    input  logic              in_display,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  pix_data,
    input  logic              w0_req,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [PIX_W-1:0]  w0_data,
    output logic              w0_gnt,
    input  logic              w1_req,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [PIX_W-1:0]  w1_data,
    output logic              w1_gnt,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              front_bank
);

    localparam logic [ADDR_W-1:0] FB_SIZE    = ADDR_W'(HRES * VRES);
    localparam logic [9:0]        VBLANK_ROW = 10'(2 * VRES);

    arb_state_e        state_r;
    logic [9:0]        col_q_r;
    logic [9:0]        row_q_r;
    logic              front_bank_r;
    logic              pending_r;
    logic              rd_valid_r;
    logic [PIX_W-1:0]  pix_r;

    logic              fetch_s;
    logic              vblank_start_s;
    logic              wr_any_s;
    logic              wr_ok_s;
    logic [1:0]        wr_req_s;
    logic [1:0]        wr_gnt_s;
    logic [ADDR_W-1:0] disp_addr_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [PIX_W-1:0]  wr_data_s;

    assign fetch_s        = (col != col_q_r) && in_display && !col[0];
    assign vblank_start_s = (row != row_q_r) && (row == VBLANK_ROW);
    assign disp_addr_s    = ADDR_W'(row[9:1]) * ADDR_W'(HRES) + ADDR_W'(col[9:1]);

    // A writer still showing its grant is masked so a lingering req is not served twice
    assign wr_req_s = {w1_req & ~w1_gnt, w0_req & ~w0_gnt};
    assign wr_any_s = |wr_gnt_s;
    assign wr_ok_s  = (wr_addr_s < FB_SIZE);

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req    (wr_req_s),
        .enable (!fetch_s),
        .gnt    (wr_gnt_s)
    );

    // Selected writer's address and data
    always_comb begin
        wr_addr_s = w0_addr;
        wr_data_s = w0_data;
        if (wr_gnt_s[1]) begin
            wr_addr_s = w1_addr;
            wr_data_s = w1_data;
        end else begin
            wr_addr_s = w0_addr;
            wr_data_s = w0_data;
        end
    end

    // Arbiter FSM: one RAM access decided per cycle, all bus and grant outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {(ADDR_W + 1){1'b0}};
            mem_wdata <= {PIX_W{1'b0}};
            w0_gnt    <= 1'b0;
            w1_gnt    <= 1'b0;
        end else if (fetch_s) begin
            state_r   <= ST_DISP_RD;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {front_bank_r, disp_addr_s};
            mem_wdata <= {PIX_W{1'b0}};
            w0_gnt    <= 1'b0;
            w1_gnt    <= 1'b0;
        end else if (wr_any_s) begin
            state_r   <= ST_WR;
            mem_en    <= wr_ok_s;
            mem_we    <= wr_ok_s;
            mem_addr  <= {~front_bank_r, wr_addr_s};
            mem_wdata <= wr_data_s;
            w0_gnt    <= wr_gnt_s[0];
            w1_gnt    <= wr_gnt_s[1];
        end else begin
            state_r   <= ST_IDLE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= mem_addr;
            mem_wdata <= mem_wdata;
            w0_gnt    <= 1'b0;
            w1_gnt    <= 1'b0;
        end
    end

    // Bank swap: a request waits for the next vertical-blank start, extra requests fold in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_bank_r <= 1'b0;
            pending_r    <= 1'b0;
            swap_ack     <= 1'b0;
        end else if (vblank_start_s && (pending_r || swap_req)) begin
            front_bank_r <= ~front_bank_r;
            pending_r    <= 1'b0;
            swap_ack     <= 1'b1;
        end else begin
            front_bank_r <= front_bank_r;
            pending_r    <= pending_r | swap_req;
            swap_ack     <= 1'b0;
        end
    end

    // Counter history and read-return pipeline (RAM data is valid one cycle after the bus read)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q_r    <= 10'd0;
            row_q_r    <= 10'd0;
            rd_valid_r <= 1'b0;
            pix_r      <= {PIX_W{1'b0}};
        end else begin
            col_q_r    <= col;
            row_q_r    <= row;
            rd_valid_r <= (state_r == ST_DISP_RD);
            if (rd_valid_r) begin
                pix_r <= mem_rdata;
            end else begin
                pix_r <= pix_r;
            end
        end
    end

    assign pix_data   = in_display ? pix_r : {PIX_W{1'b0}};
    assign front_bank = front_bank_r;

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter HRES, 320, framebuffer width in pixels (display column scaled by 2).
REQ-002 Parameter VRES, 240, framebuffer height in pixels (display row scaled by 2).
REQ-003 Parameter PIX_W, 4, pixel data width.
REQ-004 Parameter ADDR_W, 17, per-bank pixel address width; HRES*VRES SHALL fit in ADDR_W bits.
REQ-005 Ports SHALL be: clk in 1 system clock; rst in 1 reset, asynchronous, active-high.
REQ-006 row in 10, col in 10, in_display in 1: timing-generator counters and display-interval flag.
REQ-007 mem_en out 1, mem_we out 1, mem_addr out ADDR_W+1 ({bank, addr}), mem_wdata out PIX_W, mem_rdata in PIX_W: single-port framebuffer RAM, 1-cycle read latency.
REQ-008 pix_data out PIX_W: pixel to DAC; w0_req in 1, w0_addr in ADDR_W, w0_data in PIX_W, w0_gnt out 1; w1_* identical for writer 1.
REQ-009 swap_req in 1 (1-cycle pulse), swap_ack out 1, front_bank out 1.

Function
REQ-010 The block SHALL grant at most one RAM access per clk cycle; all mem_* outputs and gnt outputs SHALL be registered.
REQ-011 Display fetch SHALL be requested in the cycle where col differs from its registered copy, in_display=1 and col[0]=0.
REQ-012 Display address SHALL be (row>>1)*HRES + (col>>1), bank = front_bank, mem_we=0.
REQ-013 Display fetch SHALL have absolute priority over writers in that cycle.
REQ-014 pix_data SHALL load mem_rdata two clk cycles after the fetch decision edge and hold until the next fetch completes; pix_data SHALL be 0 whenever in_display=0.
REQ-015 Writers SHALL use req/gnt: writer holds req, addr and data stable until gnt; gnt is a 1-cycle pulse coincident with the write on the mem bus; req may be deasserted the cycle after gnt.
REQ-016 Writers SHALL be served only in cycles with no display fetch; writes target bank ~front_bank.
REQ-017 With both writers requesting, grant SHALL alternate round-robin (writer not last granted wins); after reset, writer 0 wins first.
REQ-018 Write with addr >= HRES*VRES SHALL be granted but suppressed (mem_en=0).
REQ-019 Arbiter FSM SHALL have states IDLE, DISP_RD and WR; each state lasts one cycle; next state is chosen per REQ-011..017 every cycle.
REQ-020 swap_req SHALL set a pending flag; a swap_req while pending SHALL be ignored.
REQ-021 At vertical-blank start (row changes to 2*VRES), if pending, front_bank SHALL toggle, pending SHALL clear and swap_ack SHALL pulse for one cycle.
REQ-022 A write decided on the swap edge SHALL go to the pre-swap back bank.
REQ-023 Simultaneous swap_req and vblank-start edge SHALL swap in that same edge.

Reset
REQ-024 On rst, regardless of operation in progress: mem_en, mem_we, mem_addr, mem_wdata, pix_data, w0_gnt, w1_gnt and swap_ack SHALL be 0; front_bank 0; pending cleared; FSM IDLE; round-robin pointer favours writer 0.
REQ-025 Any write not yet granted at reset SHALL be lost; writers SHALL re-request.

Structure
REQ-026 HRES, VRES, PIX_W, ADDR_W and the display-timing constants (640/480 display, porch and pulse widths) SHALL live in a shared vga_pkg package used by the timing generator and this block.
REQ-027 The two-writer round-robin SHALL be a sub-module rr_arb2 (req[1:0], enable -> one-hot gnt, pointer update).

Verification
REQ-028 in_display=1, row=10, col steps 100->101->102 every 2 clk -> one read at addr 5*320+50=1650, bank 0, on the col=100 change only; pix_data = RAM value 2 cycles later.
REQ-029 w0_req and w1_req held, addr 5 and 6, no display -> gnt order w0,w1,w0,...; mem_we=1, bank 1 each.
REQ-030 w0_req held during display fetch cycles -> w0_gnt never coincides with a display read; write completes in next free cycle.
REQ-031 swap_req pulse at row=100, then row 479->480 -> front_bank 0->1, swap_ack one cycle at that edge; second swap_req before then -> only one toggle.
REQ-032 w1 write addr 76800 -> w1_gnt pulses, mem_en stays 0.
REQ-033 rst asserted mid-frame with w0_req pending and front_bank=1 -> all outputs 0, front_bank 0 immediately; after release, w0 granted first.
